skintone_classifier_pipe: RTL and testbench

// - Parametrised, stall-capable successor to the fixed skintone datapath: per-pixel elliptical Cb/Cr skin test + 8-bit score.
// - Ellipse constants in run-time config registers (not compile-time); valid/ready on both sides; score or binary-mask mode.
// - Sits between the YCbCr pixel stream source and the skin-map writer.

---
 rtl/skintone_classifier_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_skintone_classifier_pipe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skintone_classifier_pipe.sv
// rtl/skintone_classifier_pipe.sv - elliptical Cb/Cr skin classifier, 6-stage stallable pipeline
// Optional feature macro: SKIN_STATS_EN (adds skin_count/stats_valid per-frame skin statistics).
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   in_pixel/in_last/in_valid/in_ready     {Y,Cb,Cr} pixel stream in (Y ignored)
//   out_score/out_last/out_valid/out_ready score or mask stream out
//   mode             0 graded score, 1 binary mask (travels with the pixel)
//   cfg_we/cfg_addr/cfg_wdata/cfg_ack      ellipse config write port, ack pulse on acceptance
//   skin_count, stats_valid                per-frame skin pixel count (SKIN_STATS_EN only)
module skintone_classifier_pipe #(
  parameter int PIX_W    = 8,
  parameter int FP_WIDTH = 32,
  parameter int FP_FRAC  = 16,
  parameter int SCORE_W  = 8,
  parameter int CNT_W    = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3*PIX_W-1:0]  in_pixel,
  input  logic                in_last,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [SCORE_W-1:0]  out_score,
  output logic                out_last,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                mode,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_addr,
  input  logic [FP_WIDTH-1:0] cfg_wdata,
  output logic                cfg_ack
`ifdef SKIN_STATS_EN
  ,
  output logic [CNT_W-1:0]    skin_count,
  output logic                stats_valid
`endif
);

  typedef logic signed [FP_WIDTH-1:0] fp_t;

  localparam fp_t SCORE_MAX = fp_t'((1 << SCORE_W) - 1);

  // Full-width signed product, arithmetic shift back to FP_FRAC, wrap to FP_WIDTH.
  function automatic fp_t fp_mul(input fp_t a, input fp_t b);
    logic signed [2*FP_WIDTH-1:0] p;
    p = $signed({{FP_WIDTH{a[FP_WIDTH-1]}}, a}) * $signed({{FP_WIDTH{b[FP_WIDTH-1]}}, b});
    return fp_t'(p >>> FP_FRAC);
  endfunction

  // Unsigned pixel component as a fixed-point integer value.
  function automatic fp_t pix_to_fp(input logic [PIX_W-1:0] c);
    return fp_t'({{(FP_WIDTH-PIX_W){1'b0}}, c} << FP_FRAC);
  endfunction

  // Config registers
  fp_t cx, cy, cos_k, sin_k, ecx, ecy, a2inv, b2inv, radius, fac;

  // Pipeline state; stage 6 is the output register itself
  logic v1, v2, v3, v4, v5;
  logic m1, m2, m3, m4, m5;
  logic l1, l2, l3, l4, l5;
  fp_t  s1_dx, s1_dy, s2_u, s2_v, s3_u, s3_v, s4_u2, s4_v2, s5_d;

  logic en, accept, busy, cfg_ok;
  logic [PIX_W-1:0] cb, cr;
  logic unused_y;

  assign cb       = in_pixel[2*PIX_W-1:PIX_W];
  assign cr       = in_pixel[PIX_W-1:0];
  assign unused_y = ^in_pixel[3*PIX_W-1:2*PIX_W];

  // Single global enable: the whole pipe freezes while the output is held.
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;
  assign accept   = in_valid & en;

  // Config may only change while nothing is in flight, so every pixel of a
  // stream sees one consistent set of constants.
  assign busy   = v1 | v2 | v3 | v4 | v5 | out_valid;
  assign cfg_ok = cfg_we & ~busy & ~accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cx <= '0; cy <= '0; cos_k <= '0; sin_k <= '0; ecx <= '0;
      ecy <= '0; a2inv <= '0; b2inv <= '0; radius <= '0; fac <= '0;
      cfg_ack <= 1'b0;
    end else begin
      cfg_ack <= cfg_ok;
      if (cfg_ok) begin
        case (cfg_addr)
          4'd0: cx     <= fp_t'(cfg_wdata);
          4'd1: cy     <= fp_t'(cfg_wdata);
          4'd2: cos_k  <= fp_t'(cfg_wdata);
          4'd3: sin_k  <= fp_t'(cfg_wdata);
          4'd4: ecx    <= fp_t'(cfg_wdata);
          4'd5: ecy    <= fp_t'(cfg_wdata);
          4'd6: a2inv  <= fp_t'(cfg_wdata);
          4'd7: b2inv  <= fp_t'(cfg_wdata);
          4'd8: radius <= fp_t'(cfg_wdata);
          4'd9: fac    <= fp_t'(cfg_wdata);
          default: ;
        endcase
      end
    end
  end

  // Stage 6 score computation
  fp_t s6_q, s6_int;
  logic [SCORE_W-1:0] score_c;

  always_comb begin
    s6_q    = fp_mul(radius - s5_d, fac);
    s6_int  = s6_q >>> FP_FRAC;
    score_c = '0;
    if (s5_d > radius)
      score_c = '0;
    else if (m5)
      score_c = '1;
    else if (s6_int < 0)
      score_c = '0;
    else if (s6_int > SCORE_MAX)
      score_c = '1;
    else
      score_c = s6_int[SCORE_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0; v5 <= 1'b0;
      m1 <= 1'b0; m2 <= 1'b0; m3 <= 1'b0; m4 <= 1'b0; m5 <= 1'b0;
      l1 <= 1'b0; l2 <= 1'b0; l3 <= 1'b0; l4 <= 1'b0; l5 <= 1'b0;
      s1_dx <= '0; s1_dy <= '0; s2_u <= '0; s2_v <= '0; s3_u <= '0;
      s3_v <= '0; s4_u2 <= '0; s4_v2 <= '0; s5_d <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_score <= '0;
    end else if (en) begin
      // S1: centre offset
      v1    <= accept;
      m1    <= mode;
      l1    <= in_last;
      s1_dx <= pix_to_fp(cb) - cx;
      s1_dy <= pix_to_fp(cr) - cy;
      // S2: rotation
      v2    <= v1;
      m2    <= m1;
      l2    <= l1;
      s2_u  <= fp_mul(cos_k, s1_dx) + fp_mul(sin_k, s1_dy);
      s2_v  <= fp_mul(cos_k, s1_dy) - fp_mul(sin_k, s1_dx);
      // S3: ellipse centre offset
      v3    <= v2;
      m3    <= m2;
      l3    <= l2;
      s3_u  <= s2_u - ecx;
      s3_v  <= s2_v - ecy;
      // S4: squares
      v4    <= v3;
      m4    <= m3;
      l4    <= l3;
      s4_u2 <= fp_mul(s3_u, s3_u);
      s4_v2 <= fp_mul(s3_v, s3_v);
      // S5: normalised distance
      v5    <= v4;
      m5    <= m4;
      l5    <= l4;
      s5_d  <= fp_mul(a2inv, s4_u2) + fp_mul(b2inv, s4_v2);
      // S6: output registers
      out_valid <= v5;
      out_last  <= l5;
      out_score <= score_c;
    end
  end

`ifdef SKIN_STATS_EN
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             out_hs;

  assign out_hs = out_valid & out_ready;

  always_comb begin
    cnt_inc = cnt;
    if (out_score != '0 && cnt != '1)
      cnt_inc = cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      skin_count  <= '0;
      stats_valid <= 1'b0;
    end else begin
      stats_valid <= 1'b0;
      if (out_hs) begin
        if (out_last) begin
          skin_count  <= cnt_inc;
          stats_valid <= 1'b1;
          cnt         <= '0;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_skintone_classifier_pipe.sv
// tb/tb_skintone_classifier_pipe.sv - randomized self-checking bench for skintone_classifier_pipe
module tb_skintone_classifier_pipe;

  localparam int PIX_W    = 8;
  localparam int FP_WIDTH = 32;
  localparam int FP_FRAC  = 16;
  localparam int SCORE_W  = 8;
  localparam int CNT_W    = 24;
  localparam longint ONE  = 65536;

  logic                clk = 1'b0;
  logic                rst;
  logic [3*PIX_W-1:0]  in_pixel;
  logic                in_last;
  logic                in_valid;
  logic                in_ready;
  logic [SCORE_W-1:0]  out_score;
  logic                out_last;
  logic                out_valid;
  logic                out_ready;
  logic                mode;
  logic                cfg_we;
  logic [3:0]          cfg_addr;
  logic [FP_WIDTH-1:0] cfg_wdata;
  logic                cfg_ack;
`ifdef SKIN_STATS_EN
  logic [CNT_W-1:0]    skin_count;
  logic                stats_valid;
`endif

  always #5 clk = ~clk;

  skintone_classifier_pipe #(
    .PIX_W(PIX_W), .FP_WIDTH(FP_WIDTH), .FP_FRAC(FP_FRAC), .SCORE_W(SCORE_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_pixel(in_pixel), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_score(out_score), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .mode(mode), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ack(cfg_ack)
`ifdef SKIN_STATS_EN
    , .skin_count(skin_count), .stats_valid(stats_valid)
`endif
  );

  int checks = 0;
  int errors = 0;
  int outcount = 0;
  longint mcfg [10];
  longint expq [$];

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: fixed-point arithmetic done in 64-bit integers.
  function automatic longint w32(input longint x);
    int t;
    t = int'(x);
    return longint'(t);
  endfunction

  function automatic longint fpm(input longint a, input longint b);
    return w32((a * b) >>> FP_FRAC);
  endfunction

  function automatic longint model(input int cb, input int cr, input bit md);
    longint dx, dy, u, v, d, q, ip;
    dx = w32((longint'(cb) << FP_FRAC) - mcfg[0]);
    dy = w32((longint'(cr) << FP_FRAC) - mcfg[1]);
    u  = w32(fpm(mcfg[2], dx) + fpm(mcfg[3], dy));
    v  = w32(fpm(mcfg[2], dy) - fpm(mcfg[3], dx));
    u  = w32(u - mcfg[4]);
    v  = w32(v - mcfg[5]);
    d  = w32(fpm(mcfg[6], fpm(u, u)) + fpm(mcfg[7], fpm(v, v)));
    if (d > mcfg[8]) return 0;
    if (md) return 255;
    q  = fpm(w32(mcfg[8] - d), mcfg[9]);
    ip = q >>> FP_FRAC;
    if (ip < 0) return 0;
    if (ip > 255) return 255;
    return ip;
  endfunction

  task automatic cfg_write(input int addr, input longint data, input bit exp_ack);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = addr[3:0];
    cfg_wdata = data[31:0];
    @(negedge clk);
    cfg_we = 1'b0;
    #1;
    check($sformatf("cfg_ack_a%0d", addr), cfg_ack, exp_ack);
    if (exp_ack && addr < 10) mcfg[addr] = data;
  endtask

  task automatic cfg_default();
    cfg_write(0, 128 * ONE, 1);
    cfg_write(1, 128 * ONE, 1);
    cfg_write(2, ONE, 1);
    cfg_write(3, 0, 1);
    cfg_write(4, 0, 1);
    cfg_write(5, 0, 1);
    cfg_write(6, 164, 1);
    cfg_write(7, 164, 1);
    cfg_write(8, ONE, 1);
    cfg_write(9, 200 * ONE, 1);
  endtask

  // One isolated pixel through an empty pipe; returns score and cycles to out_valid.
  task automatic run_one(input int cb, input int cr, input bit md, output int score, output int lat);
    @(negedge clk);
    in_pixel  = {8'd0, cb[7:0], cr[7:0]};
    in_valid  = 1'b1;
    in_last   = 1'b0;
    mode      = md;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    score = int'(out_score);
  endtask

  // One stream cycle with scoreboard bookkeeping of both handshakes.
  task automatic cycle(input bit iv, input int cb, input int cr, input bit md, input bit lst,
                       input bit ordy, output bit acc);
    longint e;
    @(negedge clk);
    in_valid  = iv;
    in_pixel  = {8'd0, cb[7:0], cr[7:0]};
    mode      = md;
    in_last   = lst;
    out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    if (acc) expq.push_back(model(cb, cr, md) * 2 + longint'(lst));
    if (out_valid && out_ready) begin
      outcount++;
      if (expq.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        e = expq.pop_front();
        check("stream_score", out_score, e >>> 1);
        check("stream_last", out_last, e & 1);
      end
    end
  endtask

  task automatic drain(input string tag);
    bit acc;
    int n;
    n = 0;
    while (expq.size() > 0 && n < 60) begin
      cycle(0, 128, 128, 0, 0, 1, acc);
      n++;
    end
    check(tag, expq.size(), 0);
  endtask

  initial begin
    int s, l, idx, base;
    bit acc;
    rst = 1'b0; in_pixel = '0; in_last = 0; in_valid = 0; out_ready = 0;
    mode = 0; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0;
    foreach (mcfg[i]) mcfg[i] = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_score", out_score, 0);
    check("rst_out_last", out_last, 0);
    check("rst_cfg_ack", cfg_ack, 0);
    rst = 1'b1;

    cfg_default();
    cfg_write(12, 5 * ONE, 1);

    run_one(128, 128, 0, s, l);
    check("centre_score", s, 200);
    check("centre_latency", l, 6);
    run_one(228, 128, 0, s, l);
    check("far_score", s, 0);
    run_one(128, 128, 1, s, l);
    check("mask_score", s, 255);
    run_one(134, 123, 0, s, l);
    check("offcentre_score", s, model(134, 123, 0));
    cfg_write(9, 300 * ONE, 1);
    run_one(128, 128, 0, s, l);
    check("sat_score", s, 255);
    cfg_write(9, 200 * ONE, 1);

    // Stall: out_ready low, 12 pixels offered back to back
    idx = 0;
    for (int c = 1; c <= 10; c++) begin
      cycle(idx < 12, 116 + 2 * idx, 125 + idx % 5, 0, idx == 11, 0, acc);
      if (acc) idx++;
      if (c == 7) check("stall_score_c7", out_score, expq[0] >>> 1);
    end
    check("stall_accepted", idx, 6);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    check("stall_score_c10", out_score, expq[0] >>> 1);
    base = outcount;
    for (int c = 0; c < 60 && (idx < 12 || expq.size() > 0); c++) begin
      cycle(idx < 12, 116 + 2 * idx, 125 + idx % 5, 0, idx == 11, 1, acc);
      if (acc) idx++;
    end
    check("resume_outputs", outcount - base, 12);

    // Config writes blocked by an accepting pixel and by a busy pipe
    @(negedge clk);
    in_valid = 1'b1; in_pixel = {8'd0, 8'd128, 8'd128}; mode = 0; in_last = 0; out_ready = 1;
    cfg_we = 1'b1; cfg_addr = 4'd9; cfg_wdata = 32'(50 * ONE);
    #1;
    check("accept_with_cfg", in_ready, 1);
    expq.push_back(model(128, 128, 0) * 2);
    @(negedge clk);
    in_valid = 1'b0; cfg_wdata = 32'(100 * ONE);
    #1;
    check("cfg_ack_accepting", cfg_ack, 0);
    @(negedge clk);
    cfg_we = 1'b0;
    #1;
    check("cfg_ack_busy", cfg_ack, 0);
    drain("busy_drain");
    run_one(128, 128, 0, s, l);
    check("fac_unchanged", s, 200);
    cfg_write(9, 100 * ONE, 1);
    run_one(128, 128, 0, s, l);
    check("fac_updated", s, 100);
    cfg_write(9, 200 * ONE, 1);

    // Reset mid-stream
    for (int i = 0; i < 4; i++) cycle(1, 126 + i, 128, 0, 0, 1, acc);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    expq.delete();
    foreach (mcfg[i]) mcfg[i] = 0;
    for (int i = 0; i < 10; i++) cycle(0, 128, 128, 0, 0, 1, acc);
    run_one(128, 128, 0, s, l);
    check("cleared_cfg_score", s, 0);
    check("cleared_cfg_latency", l, 6);
    cfg_default();

`ifdef SKIN_STATS_EN
    begin
      int pulses, cntv;
      pulses = 0; cntv = -1;
      for (int i = 0; i < 5; i++)
        cycle(1, (i == 1 || i == 3) ? 228 : 128, 128, 0, i == 4, 1, acc);
      for (int i = 0; i < 12; i++) begin
        cycle(0, 128, 128, 0, 0, 1, acc);
        if (stats_valid) begin
          pulses++;
          cntv = int'(skin_count);
        end
      end
      check("stats_pulses", pulses, 1);
      check("stats_count", cntv, 3);
    end
`endif

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(108, 148), $urandom_range(108, 148),
            $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, acc);
    end
    drain("random_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
